mod_dispatch: RTL

- Front/back-end stage wrapped around the sequential modulo unit (a mod b by repeated subtraction; ports start, a, b, result, done).
- Buffers operand pairs from an upstream valid/ready producer in a small FIFO and launches the modulo unit one operation at a time.
- Captures each remainder and presents it downstream with a valid/ready handshake, plus a per-operation cycle count.
- Intercepts b == 0, which would never terminate in the modulo unit, and returns an error result without launching the core.

---
 rtl/mod_dispatch.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mod_dispatch.sv
//------------------------------------------------------------------------------
// Module      : mod_dispatch
// Description : Operand FIFO, launch/wait/hold sequencer and result register
//               around a sequential modulo core; traps divide-by-zero.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mod_dispatch #(
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_a,
    input  logic [31:0]   in_b,
    output logic          mod_start,
    output logic [31:0]   mod_a,
    output logic [31:0]   mod_b,
    input  logic [31:0]   mod_result,
    input  logic          mod_done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_result,
    output logic          out_err,
    output logic [CW-1:0] out_cycles,
    output logic          busy
);

    localparam int             c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_FULL  = (c_AW+1)'(DEPTH);
    localparam logic [CW-1:0]  c_CMAX  = {CW{1'b1}};

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    logic [31:0]     r_fifo_a [DEPTH];
    logic [31:0]     r_fifo_b [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [1:0]      r_state;

    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_head_a;
    logic [31:0]     w_head_b;

    assign in_ready = (r_count != c_FULL);
    assign busy     = (r_state != S_IDLE) || (r_count != '0);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_state == S_IDLE) && (r_count != '0);
    assign w_head_a = r_fifo_a[r_rd_ptr];
    assign w_head_b = r_fifo_b[r_rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_a[r_wr_ptr] <= in_a;
            r_fifo_b[r_wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            mod_start  <= 1'b0;
            mod_a      <= '0;
            mod_b      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_err    <= 1'b0;
            out_cycles <= '0;
        end else begin
            mod_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        if (w_head_b == '0) begin
                            // Zero divisor would never terminate in the core.
                            out_result <= '0;
                            out_err    <= 1'b1;
                            out_cycles <= '0;
                            out_valid  <= 1'b1;
                            r_state    <= S_HOLD;
                        end else begin
                            mod_a      <= w_head_a;
                            mod_b      <= w_head_b;
                            mod_start  <= 1'b1;
                            out_cycles <= '0;
                            r_state    <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    out_cycles <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (mod_done) begin
                        out_result <= mod_result;
                        out_err    <= 1'b0;
                        out_valid  <= 1'b1;
                        r_state    <= S_HOLD;
                    end else if (out_cycles != c_CMAX) begin
                        out_cycles <= out_cycles + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
